// File: rtl/fantasy_mode_ramp.sv
// fantasy_mode_ramp
//   Per-mode parameter table {inv_en, shift, gain} with frame-rate ramping.
//   On each frame tick (rising edge of vs_i) the entry selected by mode_i becomes
//   the target. gain/shift move at most STEP_G/STEP_S per frame toward it. An
//   inversion change is hidden by fading gain and shift to 0, swapping inv_en
//   while both are 0, and then fading back in.
// Ports
//   clk_i        pixel clock
//   rst_i        synchronous reset, active high (restores table and outputs)
//   vs_i         vsync, rising edge = frame tick
//   mode_i       requested mode, sampled on frame tick only
//   cfg_we_i     table write strobe
//   cfg_addr_i   table entry index (out-of-range writes ignored)
//   cfg_inv_i    entry inv_en
//   cfg_shift_i  entry shift (two's complement)
//   cfg_gain_i   entry gain (UNITY = x1.0)
//   inv_en_o     current inversion enable (registered)
//   shift_o      current shift (registered, two's complement)
//   gain_o       current gain (registered)
//   busy_o       high while a fade sequence is in progress
module fantasy_mode_ramp #(
    parameter int NMODES = 8,
    parameter int GW     = 18,
    parameter int SW     = 30,
    parameter int UNITY  = 32768,
    parameter int STEP_G = 2048,
    parameter int STEP_S = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      vs_i,
    input  logic [$clog2(NMODES)-1:0] mode_i,
    input  logic                      cfg_we_i,
    input  logic [$clog2(NMODES)-1:0] cfg_addr_i,
    input  logic                      cfg_inv_i,
    input  logic [SW-1:0]             cfg_shift_i,
    input  logic [GW-1:0]             cfg_gain_i,
    output logic                      inv_en_o,
    output logic [SW-1:0]             shift_o,
    output logic [GW-1:0]             gain_o,
    output logic                      busy_o
);

    localparam logic        [GW:0] STEP_GX = (GW+1)'(STEP_G);
    localparam logic signed [SW:0] STEP_SX = (SW+1)'(STEP_S);

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} state_t;

    function automatic logic def_inv(input int i);
        def_inv = (i == 0) || (i == 1);
    endfunction

    function automatic logic [GW-1:0] def_gain(input int i);
        case (i)
            1, 6:    def_gain = GW'(21845);
            5:       def_gain = GW'(13763);
            default: def_gain = GW'(UNITY);
        endcase
    endfunction

    // One frame of unsigned gain movement toward dst, evaluated at GW+1 bits.
    function automatic logic [GW-1:0] step_gain(input logic [GW-1:0] cur,
                                                input logic [GW-1:0] dst);
        logic [GW:0] c, d;
        c = {1'b0, cur};
        d = {1'b0, dst};
        if (d >= c)
            step_gain = ((d - c) <= STEP_GX) ? dst : GW'(c + STEP_GX);
        else
            step_gain = ((c - d) <= STEP_GX) ? dst : GW'(c - STEP_GX);
    endfunction

    // One frame of signed shift movement toward dst, evaluated at SW+1 bits.
    function automatic logic signed [SW-1:0] step_shift(input logic signed [SW-1:0] cur,
                                                        input logic signed [SW-1:0] dst);
        logic signed [SW:0] c, d, diff;
        c    = {cur[SW-1], cur};
        d    = {dst[SW-1], dst};
        diff = d - c;
        if (diff > STEP_SX)
            step_shift = SW'(c + STEP_SX);
        else if (diff < -STEP_SX)
            step_shift = SW'(c - STEP_SX);
        else
            step_shift = dst;
    endfunction

    logic                  tbl_inv   [NMODES];
    logic signed [SW-1:0]  tbl_shift [NMODES];
    logic        [GW-1:0]  tbl_gain  [NMODES];

    logic                  vs_q;
    logic                  tick;
    state_t                state;
    logic                  cur_inv;
    logic signed [SW-1:0]  cur_shift;
    logic        [GW-1:0]  cur_gain;

    logic                  nt_inv;
    logic signed [SW-1:0]  nt_shift;
    logic        [GW-1:0]  nt_gain;
    logic        [GW-1:0]  g_zero, g_tgt;
    logic signed [SW-1:0]  s_zero, s_tgt;

    assign tick = vs_i & ~vs_q;

    // Target for this frame comes from the table contents before any same-cycle write.
    always_comb begin
        nt_inv   = 1'b0;
        nt_shift = '0;
        nt_gain  = GW'(UNITY);
        if (int'(mode_i) < NMODES) begin
            nt_inv   = tbl_inv[mode_i];
            nt_shift = tbl_shift[mode_i];
            nt_gain  = tbl_gain[mode_i];
        end
    end

    always_comb begin
        g_zero = step_gain(cur_gain, '0);
        s_zero = step_shift(cur_shift, '0);
        g_tgt  = step_gain(cur_gain, nt_gain);
        s_tgt  = step_shift(cur_shift, nt_shift);
    end

    // Frame-tick register stage: table, current parameters and fade state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NMODES; i++) begin
                tbl_inv[i]   <= def_inv(i);
                tbl_shift[i] <= '0;
                tbl_gain[i]  <= def_gain(i);
            end
            vs_q      <= 1'b0;
            state     <= IDLE;
            busy_o    <= 1'b0;
            cur_inv   <= 1'b0;
            cur_shift <= '0;
            cur_gain  <= GW'(UNITY);
        end else begin
            vs_q <= vs_i;
            if (cfg_we_i && (int'(cfg_addr_i) < NMODES)) begin
                tbl_inv[cfg_addr_i]   <= cfg_inv_i;
                tbl_shift[cfg_addr_i] <= cfg_shift_i;
                tbl_gain[cfg_addr_i]  <= cfg_gain_i;
            end
            if (tick) begin
                case (state)
                    IDLE, FADE_IN: begin
                        if (nt_inv != cur_inv) begin
                            // Inversion change: start hiding the image first.
                            cur_gain  <= g_zero;
                            cur_shift <= s_zero;
                            state     <= FADE_OUT;
                            busy_o    <= 1'b1;
                        end else begin
                            cur_gain  <= g_tgt;
                            cur_shift <= s_tgt;
                            if (state == FADE_IN && g_tgt == nt_gain && s_tgt == nt_shift) begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                    FADE_OUT: begin
                        cur_gain  <= g_zero;
                        cur_shift <= s_zero;
                        if (g_zero == '0 && s_zero == '0)
                            state <= SWAP;
                    end
                    default: begin
                        // SWAP: gain and shift are both 0 here, so the flip is invisible.
                        cur_inv <= nt_inv;
                        state   <= FADE_IN;
                    end
                endcase
            end
        end
    end

    assign inv_en_o = cur_inv;
    assign shift_o  = cur_shift;
    assign gain_o   = cur_gain;

endmodule
